// File: rtl/mem_access_unit.sv
// Load/store front end for the MEM stage: turns byte/halfword/word pipeline
// requests into word-aligned data memory accesses. Loads are zero-latency
// with lane select and extension. Sub-word stores use a two-cycle
// read-modify-write and stall the pipeline for one cycle. Misaligned or
// illegal requests are suppressed and the first one is recorded.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        MemSize,
  input  logic              MemSigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] storeData,
  output logic [DATA_W-1:0] loadData,
  output logic              stall,
  output logic              misalign,
  output logic              fault,
  output logic [ADDR_W-1:0] faultAddr,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWriteData,
  output logic              dMemWrite,
  output logic              dMemRead,
  input  logic [DATA_W-1:0] memReadData
);

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   merge_q, merge_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic                fault_q;
  logic [ADDR_W-1:0]   fault_addr_q;

  logic                req;
  logic                illegal;
  logic [ADDR_W-1:0]   word_addr;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [DATA_W-1:0]   load_ext;
  logic [DATA_W-1:0]   merged;

  assign req       = MemRead | MemWrite;
  assign word_addr = {addr[ADDR_W-1:2], 2'b00};

  // Alignment / legality of the presented request size.
  always_comb begin
    unique case (MemSize)
      SZ_BYTE: illegal = 1'b0;
      SZ_HALF: illegal = addr[0];
      SZ_WORD: illegal = (addr[1:0] != 2'b00);
      default: illegal = 1'b1;
    endcase
  end

  // Requests arriving while the RMW write cycle runs are the held store, not new work.
  assign misalign = (state_q == IDLE) && req && illegal;

  // Little-endian lane select and sign/zero extension for loads.
  always_comb begin
    byte_sel = memReadData[{addr[1:0], 3'b000} +: 8];
    half_sel = memReadData[{addr[1], 4'b0000} +: 16];
    unique case (MemSize)
      SZ_BYTE: load_ext = {{(DATA_W-8){MemSigned & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_ext = {{(DATA_W-16){MemSigned & half_sel[15]}}, half_sel};
      default: load_ext = memReadData;
    endcase
  end

  // Old word with the target lane replaced by the sub-word store data.
  always_comb begin
    merged = memReadData;
    if (MemSize == SZ_BYTE) merged[{addr[1:0], 3'b000} +: 8] = storeData[7:0];
    else                    merged[{addr[1], 4'b0000} +: 16] = storeData[15:0];
  end

  // Memory strobes, pipeline outputs and next-state; reset forces everything idle.
  always_comb begin
    loadData     = '0;
    stall        = 1'b0;
    memAddr      = '0;
    memWriteData = '0;
    dMemWrite    = 1'b0;
    dMemRead     = 1'b0;
    state_d      = state_q;
    merge_d      = merge_q;
    waddr_d      = waddr_q;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (req && !illegal) begin
            memAddr = word_addr;
            if (MemWrite) begin
              if (MemSize == SZ_WORD) begin
                dMemWrite    = 1'b1;
                memWriteData = storeData;
              end else begin
                dMemRead = 1'b1;
                stall    = 1'b1;
                merge_d  = merged;
                waddr_d  = word_addr;
                state_d  = RMW_WR;
              end
            end else begin
              dMemRead = 1'b1;
              loadData = load_ext;
            end
          end
        end
        RMW_WR: begin
          dMemWrite    = 1'b1;
          memAddr      = waddr_q;
          memWriteData = merge_q;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, RMW holding registers and the sticky first-fault record.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      merge_q      <= '0;
      waddr_q      <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
      waddr_q <= waddr_d;
      if (misalign) begin
        fault_q <= 1'b1;
        if (!fault_q) fault_addr_q <= addr;
      end
    end
  end

  assign fault     = fault_q;
  assign faultAddr = fault_addr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word-addressed data memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, MemSigned;
  logic [1:0]  MemSize;
  logic [31:0] addr, storeData, loadData, faultAddr, memAddr, memWriteData, memReadData;
  logic        stall, misalign, fault, dMemWrite, dMemRead;

  logic [31:0] mem [0:63];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Data memory: combinational read, write on rising edge.
  assign memReadData = mem[memAddr[7:2]];
  always @(posedge clk) if (dMemWrite) mem[memAddr[7:2]] <= memWriteData;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemSize(MemSize), .MemSigned(MemSigned), .addr(addr), .storeData(storeData),
    .loadData(loadData), .stall(stall), .misalign(misalign), .fault(fault),
    .faultAddr(faultAddr), .memAddr(memAddr), .memWriteData(memWriteData),
    .dMemWrite(dMemWrite), .dMemRead(dMemRead), .memReadData(memReadData)
  );

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] d);
    MemRead = rd; MemWrite = wr; MemSize = sz; MemSigned = sg; addr = a; storeData = d;
  endtask

  task automatic idle_req();
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
  endtask

  // Advance one cycle: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    tests++; if (dMemRead !== 1'b0) begin fails++; $display("FAIL reset_dMemRead got %0b exp 0", dMemRead); end
    tests++; if (loadData !== 32'h0) begin fails++; $display("FAIL reset_loadData got %h exp 0", loadData); end
    step();
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL reset_fault got %0b exp 0", fault); end
    tests++; if (faultAddr !== 32'h0) begin fails++; $display("FAIL reset_faultAddr got %h exp 0", faultAddr); end
    reset = 1'b0;
    idle_req();
    @(negedge clk);
    tests++; if ({stall, dMemRead, dMemWrite, memAddr, memWriteData, loadData} !== '0) begin
      fails++; $display("FAIL idle_outputs got st=%0b rd=%0b wr=%0b a=%h wd=%h ld=%h exp all 0",
                        stall, dMemRead, dMemWrite, memAddr, memWriteData, loadData);
    end
    step();
  endtask

  task automatic test_word_load();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    tests++; if (loadData !== 32'h8899AABB) begin fails++; $display("FAIL lw_data got %h exp 8899aabb", loadData); end
    tests++; if ({stall, dMemRead, dMemWrite} !== 3'b010) begin fails++; $display("FAIL lw_strobes got %b exp 010", {stall, dMemRead, dMemWrite}); end
    tests++; if (memAddr !== 32'h10) begin fails++; $display("FAIL lw_memAddr got %h exp 10", memAddr); end
    step();
  endtask

  task automatic test_subword_loads();
    logic [1:0]  sz [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        sg [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ad [4] = '{32'h13, 32'h13, 32'h10, 32'h12};
    logic [31:0] ex [4] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFFAABB, 32'h00008899};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, sz[i], sg[i], ad[i], 32'h0);
      @(negedge clk);
      tests++; if (loadData !== ex[i]) begin fails++; $display("FAIL subload_%0d got %h exp %h", i, loadData, ex[i]); end
      tests++; if ({stall, dMemRead} !== 2'b01) begin fails++; $display("FAIL subload_%0d_strobe got %b exp 01", i, {stall, dMemRead}); end
      step();
    end
  endtask

  task automatic test_byte_store();
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000CC);
    @(negedge clk);
    tests++; if ({stall, dMemRead, dMemWrite} !== 3'b110) begin fails++; $display("FAIL sb_c1_strobes got %b exp 110", {stall, dMemRead, dMemWrite}); end
    step();
    @(negedge clk);
    tests++; if ({stall, dMemRead, dMemWrite} !== 3'b001) begin fails++; $display("FAIL sb_c2_strobes got %b exp 001", {stall, dMemRead, dMemWrite}); end
    tests++; if (memWriteData !== 32'h8899CCBB) begin fails++; $display("FAIL sb_c2_wdata got %h exp 8899ccbb", memWriteData); end
    tests++; if (memAddr !== 32'h10) begin fails++; $display("FAIL sb_c2_memAddr got %h exp 10", memAddr); end
    tests++; if (loadData !== 32'h0) begin fails++; $display("FAIL sb_c2_loadData got %h exp 0", loadData); end
    step();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    tests++; if (loadData !== 32'h8899CCBB) begin fails++; $display("FAIL sb_readback got %h exp 8899ccbb", loadData); end
    step();
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234);
    @(negedge clk);
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL sh_c1_stall got %0b exp 1", stall); end
    step();
    @(negedge clk);
    tests++; if ({dMemWrite, memWriteData} !== {1'b1, 32'h1234CCBB}) begin fails++; $display("FAIL sh_c2_write got we=%0b %h exp 1 1234ccbb", dMemWrite, memWriteData); end
    step();
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h00000055);
    @(negedge clk);
    tests++; if ({stall, dMemRead} !== 2'b11) begin fails++; $display("FAIL sb2_c1_strobes got %b exp 11", {stall, dMemRead}); end
    step();
    @(negedge clk);
    tests++; if ({dMemWrite, memWriteData} !== {1'b1, 32'h1234CC55}) begin fails++; $display("FAIL sb2_c2_write got we=%0b %h exp 1 1234cc55", dMemWrite, memWriteData); end
    step();
    // Read and write together behave as a word store with no load data.
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D);
    @(negedge clk);
    tests++; if ({dMemWrite, dMemRead, stall, loadData} !== {3'b100, 32'h0}) begin fails++; $display("FAIL rdwr_store got we=%0b rd=%0b st=%0b ld=%h exp 1 0 0 0", dMemWrite, dMemRead, stall, loadData); end
    step();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    tests++; if (loadData !== 32'h1234CC55) begin fails++; $display("FAIL b2b_readback got %h exp 1234cc55", loadData); end
    step();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    tests++; if (loadData !== 32'hCAFEF00D) begin fails++; $display("FAIL rdwr_readback got %h exp cafef00d", loadData); end
    step();
  endtask

  task automatic test_misalign();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
    @(negedge clk);
    tests++; if (misalign !== 1'b1) begin fails++; $display("FAIL lw_mis_flag got %0b exp 1", misalign); end
    tests++; if ({dMemRead, dMemWrite, stall, loadData} !== {3'b000, 32'h0}) begin fails++; $display("FAIL lw_mis_quiet got rd=%0b wr=%0b st=%0b ld=%h exp all 0", dMemRead, dMemWrite, stall, loadData); end
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL fault_pre_edge got %0b exp 0", fault); end
    step();
    idle_req();
    @(negedge clk);
    tests++; if ({fault, faultAddr} !== {1'b1, 32'h12}) begin fails++; $display("FAIL fault_first got %0b %h exp 1 12", fault, faultAddr); end
    step();
    drive(1'b1, 1'b0, 2'b01, 1'b1, 32'h21, 32'h0);
    @(negedge clk);
    tests++; if (misalign !== 1'b1) begin fails++; $display("FAIL lh_mis_flag got %0b exp 1", misalign); end
    step();
    idle_req();
    @(negedge clk);
    tests++; if ({fault, faultAddr} !== {1'b1, 32'h12}) begin fails++; $display("FAIL fault_sticky got %0b %h exp 1 12", fault, faultAddr); end
    step();
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h13, 32'h0000BEEF);
    @(negedge clk);
    tests++; if ({misalign, dMemWrite, dMemRead, stall} !== 4'b1000) begin fails++; $display("FAIL sh_mis got %b exp 1000", {misalign, dMemWrite, dMemRead, stall}); end
    step();
    drive(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    tests++; if ({misalign, dMemRead} !== 2'b10) begin fails++; $display("FAIL size11_mis got %b exp 10", {misalign, dMemRead}); end
    step();
    idle_req();
    @(negedge clk);
    tests++; if (mem[4] !== 32'h1234CC55) begin fails++; $display("FAIL mis_no_write got %h exp 1234cc55", mem[4]); end
    step();
  endtask

  task automatic test_reset_in_rmw();
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h000000EE);
    @(negedge clk);
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL rst_rmw_c1_stall got %0b exp 1", stall); end
    step();
    reset = 1'b1;
    @(negedge clk);
    tests++; if (dMemWrite !== 1'b0) begin fails++; $display("FAIL rst_rmw_we got %0b exp 0", dMemWrite); end
    step();
    reset = 1'b0;
    idle_req();
    @(negedge clk);
    tests++; if (mem[4] !== 32'h1234CC55) begin fails++; $display("FAIL rst_rmw_mem got %h exp 1234cc55", mem[4]); end
    tests++; if ({stall, fault, faultAddr} !== {2'b00, 32'h0}) begin fails++; $display("FAIL rst_rmw_state got st=%0b f=%0b fa=%h exp 0 0 0", stall, fault, faultAddr); end
    step();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'h8899AABB;
    reset = 1'b1;
    idle_req();
    #1;
    test_reset();
    test_word_load();
    test_subword_loads();
    test_byte_store();
    test_back_to_back();
    test_misalign();
    test_reset_in_rmw();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
